// File: rtl/p2s_pkg.sv
// Shared types and constants for the parallel-to-serial transmitter.
package p2s_pkg;

  localparam int P2S_DW  = 32;
  localparam int P2S_DIV = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } p2s_state_e;

  // Counter width for a modulus of n, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/p2s_if.sv
// Word-in / serial-out handshake bundle between the datapath and p2s_tx.
interface p2s_if #(
  parameter int DW = 32
);
  logic          start;
  logic [DW-1:0] din;
  logic          busy;
  logic          done;
  logic          sclk;
  logic          sdata;
  logic          slatch;

  modport master (output start, din, input busy, done, sclk, sdata, slatch);
  modport slave  (input start, din, output busy, done, sclk, sdata, slatch);
endinterface

// File: rtl/p2s_tick.sv
// DIV-cycle divider: o_tc marks the last cycle of each DIV-cycle interval.
module p2s_tick
  import p2s_pkg::*;
#(
  parameter int DIV = P2S_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);
  localparam int            CW   = cnt_w(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tc = i_en && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || i_clr) r_cnt <= '0;
    else if (i_en)    r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
  end
endmodule

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: shifts a captured word out MSB-first on a
// divided clock, then strobes slatch so the downstream chain updates.
module p2s_tx
  import p2s_pkg::*;
#(
  parameter int DW  = P2S_DW,
  parameter int DIV = P2S_DIV
) (
  input  logic clk,
  input  logic rst,
  p2s_if.slave bus
);
  localparam int            BW       = cnt_w(DW);
  localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

  p2s_state_e    r_state, w_state_nx;
  logic [DW-1:0] r_shreg, w_shreg_nx;
  logic [BW-1:0] r_bitcnt, w_bitcnt_nx;
  logic          r_phase, w_phase_nx;
  logic          r_busy, w_busy_nx;
  logic          r_done, w_done_nx;
  logic          r_sclk, w_sclk_nx;
  logic          r_sdata, w_sdata_nx;
  logic          r_slatch, w_slatch_nx;
  logic          w_tick, w_div_en;

  // The divider is held cleared in IDLE so every transfer starts phase-aligned.
  assign w_div_en = (r_state != ST_IDLE);

  p2s_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .i_clr (!w_div_en),
    .i_en  (w_div_en),
    .o_tc  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_state_nx = ST_SHIFT;
      ST_SHIFT: if (w_tick && r_phase && (r_bitcnt == '0)) w_state_nx = ST_LATCH;
      ST_LATCH: if (w_tick) w_state_nx = ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  // Next values for the datapath and the registered outputs.
  always_comb begin
    w_shreg_nx  = r_shreg;
    w_bitcnt_nx = r_bitcnt;
    w_phase_nx  = r_phase;
    w_busy_nx   = r_busy;
    w_done_nx   = 1'b0;
    w_sclk_nx   = r_sclk;
    w_sdata_nx  = r_sdata;
    w_slatch_nx = r_slatch;
    case (r_state)
      ST_IDLE: if (bus.start) begin
        w_shreg_nx  = bus.din;
        w_bitcnt_nx = BIT_LAST;
        w_phase_nx  = 1'b0;
        w_busy_nx   = 1'b1;
        w_sclk_nx   = 1'b0;
        w_sdata_nx  = bus.din[DW-1];
      end
      ST_SHIFT: if (w_tick) begin
        if (!r_phase) begin
          w_phase_nx = 1'b1;
          w_sclk_nx  = 1'b1;
        end else if (r_bitcnt == '0) begin
          // Last bit stays on sdata through the latch strobe.
          w_phase_nx  = 1'b0;
          w_sclk_nx   = 1'b0;
          w_slatch_nx = 1'b1;
        end else begin
          w_shreg_nx  = {r_shreg[DW-2:0], 1'b0};
          w_bitcnt_nx = r_bitcnt - 1'b1;
          w_phase_nx  = 1'b0;
          w_sclk_nx   = 1'b0;
          w_sdata_nx  = r_shreg[DW-2];
        end
      end
      ST_LATCH: if (w_tick) begin
        w_slatch_nx = 1'b0;
        w_busy_nx   = 1'b0;
        w_done_nx   = 1'b1;
        w_sdata_nx  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_phase  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sclk   <= 1'b0;
      r_sdata  <= 1'b0;
      r_slatch <= 1'b0;
    end else begin
      r_shreg  <= w_shreg_nx;
      r_bitcnt <= w_bitcnt_nx;
      r_phase  <= w_phase_nx;
      r_busy   <= w_busy_nx;
      r_done   <= w_done_nx;
      r_sclk   <= w_sclk_nx;
      r_sdata  <= w_sdata_nx;
      r_slatch <= w_slatch_nx;
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.sclk   = r_sclk;
  assign bus.sdata  = r_sdata;
  assign bus.slatch = r_slatch;
endmodule

// File: tb/tb_p2s_tx.sv
// Bench for p2s_tx: two instances (DIV=2, DIV=1) share stimulus and are
// compared every cycle against a timeline model built from the frame timing.
module tb_p2s_tx;
  localparam int DW   = 32;
  localparam int DIV0 = 2;
  localparam int DIV1 = 1;
  localparam int LAT1 = 2 * DIV1 * DW + DIV1 + 1;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          start = 1'b1;
  logic [DW-1:0] din   = '0;

  always #5 clk = ~clk;

  p2s_if #(.DW(DW)) b0 ();
  p2s_if #(.DW(DW)) b1 ();

  assign b0.start = start;
  assign b0.din   = din;
  assign b1.start = start;
  assign b1.din   = din;

  p2s_tx #(.DW(DW), .DIV(DIV0)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
  p2s_tx #(.DW(DW), .DIV(DIV1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1));

  logic [4:0] obs0, obs1;
  assign obs0 = {b0.busy, b0.done, b0.sclk, b0.sdata, b0.slatch};
  assign obs1 = {b1.busy, b1.done, b1.sclk, b1.sdata, b1.slatch};

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state, one slot per instance.
  int            cyc = 0;
  bit            armed = 1'b0;
  bit            act   [2];
  int            acc_n [2];
  logic [DW-1:0] exp_w [2];
  logic [DW-1:0] rx    [2];
  logic          psclk [2];
  int            nacc  [2];
  int            nfrm  [2];
  int            ndone [2];
  int            blen  [2];

  // Sampled on the falling edge; inputs change just after the rising edge.
  initial begin
    for (int d = 0; d < 2; d++) begin
      act[d] = 1'b0; acc_n[d] = 0; exp_w[d] = '0; rx[d] = '0; psclk[d] = 1'b0;
      nacc[d] = 0; nfrm[d] = 0; ndone[d] = 0; blen[d] = 0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        int dv, s, lat, t;
        logic [4:0] o, e, m;
        dv  = (d == 0) ? DIV0 : DIV1;
        s   = 2 * dv * DW;
        lat = s + dv + 1;
        o   = (d == 0) ? obs0 : obs1;
        e   = '0;
        m   = 5'b11111;
        t   = 0;
        if (act[d]) begin
          t    = cyc - acc_n[d];
          e[4] = (t < lat);
          e[3] = (t == lat);
          e[0] = (t > s) && (t < lat);
          if (t <= s) begin
            e[2] = (((t - 1) / dv) % 2) == 1;
            e[1] = exp_w[d][DW - 1 - (t - 1) / (2 * dv)];
          end else if (t < lat) begin
            m[1] = 1'b0;
          end
        end
        if (armed) begin
          chk((d == 0) ? "outs_div2" : "outs_div1", {59'd0, o & m}, {59'd0, e & m});
          if (o[3]) ndone[d]++;
          if (act[d] && t == lat) begin
            chk((d == 0) ? "word_div2" : "word_div1", {32'd0, rx[d]}, {32'd0, exp_w[d]});
            chk((d == 0) ? "busylen_div2" : "busylen_div1", blen[d], lat - 1);
            nfrm[d]++;
            act[d] = 1'b0;
          end
          blen[d] = o[4] ? blen[d] + 1 : 0;
          if (o[2] && !psclk[d]) rx[d] = {rx[d][DW-2:0], o[1]};
          psclk[d] = o[2];
        end
        if (rst) begin
          act[d] = 1'b0;
        end else if (!act[d] && start) begin
          act[d]   = 1'b1;
          acc_n[d] = cyc;
          exp_w[d] = din;
          rx[d]    = '0;
          nacc[d]++;
        end
      end
      if (rst) armed = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [DW-1:0] w);
    start = 1'b1;
    din   = w;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((act[0] || act[1]) && k < 1000) begin
      step();
      k++;
    end
    chk("idle_timeout", k < 1000, 1);
  endtask

  initial begin
    int k, base, dn0, dn1;
    // Reset held two cycles with start high: nothing may launch.
    rst = 1'b1; start = 1'b1; din = $urandom;
    step(); step();
    chk("rst_outs_div2", obs0, 0);
    chk("rst_outs_div1", obs1, 0);
    rst = 1'b0; start = 1'b0;
    step(); step();

    pulse(32'hA5A5_0F0F);
    wait_idle();

    // Second start mid-transfer must be ignored.
    pulse(32'h1234_5678);
    repeat (20) step();
    pulse(32'hFFFF_FFFF);
    wait_idle();

    // start held high across two frames on the DIV=1 instance.
    base = nacc[1]; k = 0;
    start = 1'b1; din = 32'h8000_0001;
    while (nacc[1] == base && k < 10) begin step(); k++; end
    din = 32'h0000_0000;
    while (nacc[1] < base + 2 && k < 300) begin step(); k++; end
    start = 1'b0;
    chk("b2b_accepts", nacc[1] - base, 2);
    wait_idle();

    // Abort at bit 10 of the DIV=2 frame.
    dn0 = ndone[0]; dn1 = ndone[1];
    pulse(32'hDEAD_BEEF);
    k = 0;
    while ((cyc - acc_n[0]) < 1 + 2 * DIV0 * 10 && k < 200) begin step(); k++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_outs_div2", obs0, 0);
    chk("abort_outs_div1", obs1, 0);
    repeat (5) step();
    chk("abort_nodone_div2", ndone[0], dn0);
    chk("abort_nodone_div1", ndone[1], dn1);
    pulse($urandom);
    wait_idle();

    // din scrambled every cycle after capture.
    pulse(32'hCAFE_F00D);
    k = 0;
    while (act[0] && k < 400) begin din = $urandom; step(); k++; end
    wait_idle();

    // Random words with stray start pulses while both instances are busy.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) step();
      pulse($urandom);
      k = 0;
      while (act[0] && k < 400) begin
        if (act[1] && (cyc - acc_n[1]) < LAT1 - 4 && $urandom_range(0, 15) == 0) begin
          start = 1'b1;
          din   = $urandom;
        end else begin
          start = 1'b0;
        end
        step();
        k++;
      end
      start = 1'b0;
      wait_idle();
    end

    repeat (4) step();
    chk("frames_div2", nfrm[0], 11);
    chk("frames_div1", nfrm[1], 12);
    chk("dones_div2", ndone[0], nfrm[0]);
    chk("dones_div1", ndone[1], nfrm[1]);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/p2s_tx.md
# p2s_tx

Parallel-to-serial transmitter. It captures a 32-bit word on a start strobe and shifts it out MSB-first on a divided serial clock, then pulses a latch line so the downstream shift-register chain (seven-segment/LED board) can transfer the word to its outputs. It sits between the datapath's 32-bit registers (PC, IR, ALU out, display data) and the board's serial display interface. It is the reading/transmitting end of the word that those registers hold.

## Interface
Parameters:
- DW, 32, word width in bits; must be ≥ 2.
- DIV, 4, half-period of `sclk` in `clk` cycles; must be ≥ 1.

Ports:
- clk, input, 1, system clock; all logic is rising-edge.
- rst, input, 1, reset; synchronous and active-high.
- start, input, 1, request to transmit `din`; sampled only in IDLE.
- din, input, DW, word to send; captured in the cycle `start` is accepted.
- busy, output, 1, high from the cycle after acceptance until the transfer ends.
- done, output, 1, one-cycle pulse at the end of a transfer.
- sclk, output, 1, serial clock; idles low.
- sdata, output, 1, serial data; valid around each `sclk` rising edge.
- slatch, output, 1, latch strobe to the downstream chain.

## Operation
- State machine with three states:
  - IDLE: `busy`=0. If `start`=1, then load shreg←din, bitcnt←DW−1, divcnt←0, phase←0, and go to SHIFT.
  - SHIFT:
    - `sdata` = shreg[DW−1] throughout the bit.
    - phase 0: `sclk`=0 for DIV cycles.
    - phase 1: `sclk`=1 for DIV cycles.
    - At the end of phase 1: if bitcnt=0, go to LATCH with `sclk`←0 and divcnt←0. Otherwise shreg←shreg<<1 (zero fill), bitcnt−−, phase←0.
  - LATCH: `slatch`=1 and `sclk`=0 for DIV cycles, then go to IDLE with `done`=1 for exactly that one cycle.
- `start` is ignored while busy. There is no queueing and no abort input.
- `din` changes after acceptance have no effect on the transfer in progress.
- All outputs are registered; no combinational path from inputs to outputs.
- Counters:
  - divcnt width: clog2(DIV), minimum 1.
  - bitcnt width: clog2(DW).
  - Both wrap only under FSM control and never free-run in IDLE.

## Timing
- Reset: takes effect at the next `clk` edge with `rst`=1.
  - State becomes IDLE.
  - busy, done, sclk, sdata and slatch are all 0; shreg and counters are 0.
  - Reset mid-transfer aborts immediately: no `done`, no `slatch`.
- `rst` has priority over `start` in the same cycle.
- Acceptance edge E: `start`=1 in IDLE at edge E.
  - `busy`=1 from E+1.
  - `sdata`=din[DW−1] from E+1.
  - First `sclk` rise at E+1+DIV.
- Bit k (k=0 is the MSB) occupies cycles E+1+2·DIV·k through E+2·DIV·(k+1). `sdata` is stable DIV cycles before and DIV cycles after each `sclk` rise.
- `slatch` is high for cycles E+1+2·DIV·DW through E+2·DIV·DW+DIV.
- Completion cycle C = E+1+2·DIV·DW+DIV:
  - `done`=1 and `busy`=0 in C.
  - `sdata`=0 in C.
- Total latency from `start` to `done`: 2·DIV·DW+DIV+1 cycles.
- Back-to-back: `start` held high during C is accepted at C's edge; the next `busy` rises at C+1.

## Structure
- Shared package `p2s_pkg`:
  - FSM state enum {IDLE, SHIFT, LATCH}.
  - Default DW/DIV constants.
  - Width helper for the counters.
- Sub-module `p2s_tick` (DIV-cycle divider):
  - Inputs: clear, enable.
  - Output: a terminal-count pulse.
  - Reused for both SHIFT phases and LATCH.
- The rest of the logic lives in `p2s_tx`: FSM, shift register, bit counter, output registers.

## Test plan
- Reset: assert `rst` for 2 cycles with `start`=1 → all outputs 0; no transfer starts.
- Basic word (DIV=2, din=32'hA5A5_0F0F):
  - Bits sampled at `sclk` rises reassemble to 32'hA5A5_0F0F.
  - `busy` lasts 130 cycles; `slatch` high for 2 cycles; `done` pulses once, 131 cycles after `start`.
- Busy/hold-off: pulse `start` with din=32'h1234_5678, then pulse `start` again mid-transfer with din=32'hFFFF_FFFF → only 32'h1234_5678 is sent; one `done`.
- Back-to-back (DIV=1): `start` held high continuously with din=32'h8000_0001 then 32'h0000_0000 → two frames; second `busy` rises the cycle after the first `done`; frames separated by exactly one non-busy cycle.
- Mid-transfer reset: `rst` at bit 10 of 32'hDEAD_BEEF → outputs 0 next cycle; no `slatch`, no `done`. A new `start` then sends a full word correctly.
- `din` stability: change `din` every cycle during a transfer of 32'hCAFE_F00D → output is still 32'hCAFE_F00D.
